// File: rtl/power_ctrl_pkg.sv
// Purpose: shared workload codes, controller state encodings and the workload-to-level map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package power_ctrl_pkg;

   // Workload codes produced by the upstream classifier.
   localparam logic [2:0] WL_UNKNOWN   = 3'b000;
   localparam logic [2:0] WL_COMPUTE   = 3'b001;
   localparam logic [2:0] WL_MEMORY    = 3'b010;
   localparam logic [2:0] WL_CONTROL   = 3'b011;
   localparam logic [2:0] WL_MIXED     = 3'b100;
   localparam logic [2:0] WL_IDLE      = 3'b101;
   localparam logic [2:0] WL_STREAMING = 3'b110;
   localparam logic [2:0] WL_IRREGULAR = 3'b111;

   typedef enum logic [2:0] {
      ST_STEADY   = 3'd0,
      ST_RAMPUP   = 3'd1,
      ST_RAMPDOWN = 3'd2,
      ST_THROTTLE = 3'd3,
      ST_COOLDOWN = 3'd4
   } ctrl_state_t;

   // Preferred performance level for each workload class. UNKNOWN never
   // qualifies as a sample, so its entry is only a harmless mid-range value.
   function automatic logic [2:0] target_level(input logic [2:0] fmt);
      logic [2:0] lvl;
      case (fmt)
         WL_COMPUTE:   lvl = 3'd7;
         WL_MEMORY:    lvl = 3'd4;
         WL_CONTROL:   lvl = 3'd4;
         WL_MIXED:     lvl = 3'd5;
         WL_IDLE:      lvl = 3'd1;
         WL_STREAMING: lvl = 3'd6;
         WL_IRREGULAR: lvl = 3'd5;
         default:      lvl = 3'd4;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/level_hysteresis.sv
// Purpose: detects new classifier samples, qualifies them and tracks a candidate level with hit count.
// Latency: candidate/hits update on the sample edge; o_settled follows the registered hit count.
// Backpressure: none; every changed classificationCount is consumed in the cycle it appears.
// Ports: i_clk/i_reset, classifier inputs (format, confidence, valid, count),
//        o_candidateLevel (most recent qualified target), o_settled (hits reached HOLDSAMPLES).
module level_hysteresis
   import power_ctrl_pkg::*;
#(
   parameter int unsigned HOLDSAMPLES   = 3,
   parameter int unsigned MINCONFIDENCE = 6,
   parameter int unsigned RESETLEVEL    = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [2:0]  i_workloadFormat,
   input  logic [3:0]  i_workloadConfidence,
   input  logic        i_classificationValid,
   input  logic [15:0] i_classificationCount,
   output logic [2:0]  o_candidateLevel,
   output logic        o_settled
);

   localparam logic [3:0] HOLD_L     = 4'(HOLDSAMPLES);
   localparam logic [3:0] MIN_CONF_L = 4'(MINCONFIDENCE);
   localparam logic [2:0] RESET_LV_L = 3'(RESETLEVEL);

   logic [15:0] r_last_count;
   logic [2:0]  r_cand_level;
   logic [3:0]  r_cand_hits;

   logic        w_sample;
   logic        w_qualified;
   logic [2:0]  w_target;

   assign w_sample    = (i_classificationCount != r_last_count);
   assign w_qualified = w_sample && i_classificationValid &&
                        (i_workloadConfidence >= MIN_CONF_L) &&
                        (i_workloadFormat != WL_UNKNOWN);
   assign w_target    = target_level(i_workloadFormat);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last_count <= 16'd0;
         r_cand_level <= RESET_LV_L;
         r_cand_hits  <= 4'd0;
      end else begin
         if (w_sample) begin
            r_last_count <= i_classificationCount;
         end
         if (w_qualified) begin
            if (w_target == r_cand_level) begin
               // Saturate so the candidate stays settled while the workload is stable.
               if (r_cand_hits != HOLD_L) begin
                  r_cand_hits <= r_cand_hits + 4'd1;
               end
            end else begin
               r_cand_level <= w_target;
               r_cand_hits  <= 4'd1;
            end
         end
      end
   end

   assign o_candidateLevel = r_cand_level;
   assign o_settled        = (r_cand_hits == HOLD_L);

endmodule

// File: rtl/power_state_controller.sv
// Purpose: picks a 3-bit performance level from classifier output with hysteresis, rate-limited steps and budget throttling.
// Latency: reacts one edge after settle/over-budget is visible; each level step takes STEPCYCLES edges.
// Backpressure: none; over-budget preempts any ramp or cooldown on the next edge.
// Ports: i_clk/i_reset, classifier inputs, i_currentPower/i_powerBudget;
//        o_perfLevel, o_ctrlState, status flags, o_transitionCount (wraps), o_throttleEvents (saturates).
module power_state_controller
   import power_ctrl_pkg::*;
#(
   parameter int unsigned HOLDSAMPLES    = 3,
   parameter int unsigned STEPCYCLES     = 4,
   parameter int unsigned COOLDOWNCYCLES = 16,
   parameter int unsigned MINCONFIDENCE  = 6,
   parameter int unsigned RESETLEVEL     = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [2:0]  i_workloadFormat,
   input  logic [3:0]  i_workloadConfidence,
   input  logic        i_classificationValid,
   input  logic [15:0] i_classificationCount,
   input  logic [7:0]  i_currentPower,
   input  logic [7:0]  i_powerBudget,
   output logic [2:0]  o_perfLevel,
   output logic [2:0]  o_ctrlState,
   output logic        o_transitionActive,
   output logic        o_throttleActive,
   output logic        o_clkGateRequest,
   output logic [15:0] o_transitionCount,
   output logic [7:0]  o_throttleEvents
);

   localparam logic [7:0] STEP_LAST  = 8'(STEPCYCLES - 1);
   localparam logic [7:0] CD_LAST    = 8'(COOLDOWNCYCLES - 1);
   localparam logic [2:0] RESET_LV_L = 3'(RESETLEVEL);

   ctrl_state_t r_state;
   logic [2:0]  r_level;
   logic [2:0]  r_target;
   logic [7:0]  r_step_cnt;
   logic [7:0]  r_cd_cnt;
   logic [15:0] r_trans_cnt;
   logic [7:0]  r_throttle_ev;

   ctrl_state_t w_state_nxt;
   logic [2:0]  w_level_nxt;
   logic [2:0]  w_target_nxt;
   logic [7:0]  w_step_cnt_nxt;
   logic [7:0]  w_cd_cnt_nxt;
   logic [15:0] w_trans_nxt;
   logic [7:0]  w_throttle_ev_nxt;

   logic [2:0]  w_cand_level;
   logic        w_settled;
   logic        w_over;
   logic        w_step_due;
   logic [2:0]  w_eff_target;
   logic [2:0]  w_stepped_level;

   level_hysteresis #(
      .HOLDSAMPLES   (HOLDSAMPLES),
      .MINCONFIDENCE (MINCONFIDENCE),
      .RESETLEVEL    (RESETLEVEL)
   ) u_hyst (
      .i_clk                 (i_clk),
      .i_reset               (i_reset),
      .i_workloadFormat      (i_workloadFormat),
      .i_workloadConfidence  (i_workloadConfidence),
      .i_classificationValid (i_classificationValid),
      .i_classificationCount (i_classificationCount),
      .o_candidateLevel      (w_cand_level),
      .o_settled             (w_settled)
   );

   assign w_over     = (i_currentPower > i_powerBudget);
   assign w_step_due = (r_step_cnt == STEP_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_STEADY;
         r_level       <= RESET_LV_L;
         r_target      <= RESET_LV_L;
         r_step_cnt    <= 8'd0;
         r_cd_cnt      <= 8'd0;
         r_trans_cnt   <= 16'd0;
         r_throttle_ev <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_level       <= w_level_nxt;
         r_target      <= w_target_nxt;
         r_step_cnt    <= w_step_cnt_nxt;
         r_cd_cnt      <= w_cd_cnt_nxt;
         r_trans_cnt   <= w_trans_nxt;
         r_throttle_ev <= w_throttle_ev_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_level_nxt       = r_level;
      w_target_nxt      = r_target;
      w_step_cnt_nxt    = r_step_cnt;
      w_cd_cnt_nxt      = r_cd_cnt;
      w_trans_nxt       = r_trans_cnt;
      w_throttle_ev_nxt = r_throttle_ev;
      w_eff_target      = r_target;
      w_stepped_level   = r_level;

      if (w_over && (r_state != ST_THROTTLE)) begin
         // Budget violation preempts whatever else was going on.
         w_state_nxt    = ST_THROTTLE;
         w_step_cnt_nxt = 8'd0;
         if (r_throttle_ev != 8'hFF) begin
            w_throttle_ev_nxt = r_throttle_ev + 8'd1;
         end
      end else begin
         case (r_state)
            ST_STEADY: begin
               if (w_settled && (w_cand_level > r_level)) begin
                  w_state_nxt    = ST_RAMPUP;
                  w_target_nxt   = w_cand_level;
                  w_step_cnt_nxt = 8'd0;
               end else if (w_settled && (w_cand_level < r_level)) begin
                  w_state_nxt    = ST_RAMPDOWN;
                  w_target_nxt   = w_cand_level;
                  w_step_cnt_nxt = 8'd0;
               end
            end

            ST_RAMPUP, ST_RAMPDOWN: begin
               // A newly settled candidate retargets the ramp without restarting the step timer.
               if (w_settled && (w_cand_level != r_target)) begin
                  w_eff_target = w_cand_level;
               end
               w_target_nxt = w_eff_target;

               if (w_step_due) begin
                  w_step_cnt_nxt = 8'd0;
                  if (w_eff_target > r_level) begin
                     w_stepped_level = r_level + 3'd1;
                  end else if (w_eff_target < r_level) begin
                     w_stepped_level = r_level - 3'd1;
                  end
               end else begin
                  w_step_cnt_nxt = r_step_cnt + 8'd1;
               end

               w_level_nxt = w_stepped_level;
               if (w_stepped_level != r_level) begin
                  w_trans_nxt = r_trans_cnt + 16'd1;
               end

               // Direction is re-derived every cycle, so a reversed target flips the state
               // and a target equal to the (possibly just stepped) level finishes in STEADY.
               if (w_stepped_level == w_eff_target) begin
                  w_state_nxt = ST_STEADY;
               end else if (w_eff_target > w_stepped_level) begin
                  w_state_nxt = ST_RAMPUP;
               end else begin
                  w_state_nxt = ST_RAMPDOWN;
               end
            end

            ST_THROTTLE: begin
               if (!w_over) begin
                  w_state_nxt  = ST_COOLDOWN;
                  w_cd_cnt_nxt = 8'd0;
               end else if (w_step_due) begin
                  w_step_cnt_nxt = 8'd0;
                  if (r_level != 3'd0) begin
                     w_level_nxt = r_level - 3'd1;
                     w_trans_nxt = r_trans_cnt + 16'd1;
                  end
               end else begin
                  w_step_cnt_nxt = r_step_cnt + 8'd1;
               end
            end

            ST_COOLDOWN: begin
               if (r_cd_cnt == CD_LAST) begin
                  w_state_nxt = ST_STEADY;
               end else begin
                  w_cd_cnt_nxt = r_cd_cnt + 8'd1;
               end
            end

            default: begin
               w_state_nxt = ST_STEADY;
            end
         endcase
      end
   end

   assign o_perfLevel        = r_level;
   assign o_ctrlState        = r_state;
   assign o_transitionActive = (r_state == ST_RAMPUP) || (r_state == ST_RAMPDOWN);
   assign o_throttleActive   = (r_state == ST_THROTTLE);
   assign o_clkGateRequest   = (r_state == ST_STEADY) && (r_level <= 3'd1);
   assign o_transitionCount  = r_trans_cnt;
   assign o_throttleEvents   = r_throttle_ev;

endmodule
